// File: rtl/burst_err_channel_if.sv
// rtl/burst_err_channel_if.sv - symbol stream into and out of the error-injecting channel
interface burst_err_channel_if #(
    parameter int W = 2
);
    logic         valid_i;
    logic [W-1:0] d_i;
    logic [1:0]   mode_i;
    logic         valid_o;
    logic [W-1:0] d_o;
    logic [W-1:0] err_mask_o;

    modport master (
        output valid_i, d_i, mode_i,
        input  valid_o, d_o, err_mask_o
    );

    modport slave (
        input  valid_i, d_i, mode_i,
        output valid_o, d_o, err_mask_o
    );
endinterface

// File: rtl/burst_err_channel.sv
// rtl/burst_err_channel.sv - LFSR-driven random/burst/forced bit-error channel with saturating counters
module burst_err_channel #(
    parameter int          W      = 2,
    parameter int          N      = 5,
    parameter int          BURST  = 2,
    parameter int          WINDOW = 256,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    burst_err_channel_if.slave ch,
    output logic [15:0]        inj_ct_o,
    output logic [15:0]        bad_bit_ct_o,
    output logic               window_done_o
);
    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    localparam logic [15:0] POLY     = 16'hB400;
    localparam logic [15:0] TRIG_MSK = 16'((1 << N) - 1);
    localparam logic [31:0] WIN      = 32'(WINDOW);
    localparam logic [7:0]  REM_INIT = 8'(BURST - 1);
    localparam logic        MULTI    = (BURST > 1);

    state_t       r_state;
    state_t       w_state_nx;
    logic [7:0]   r_rem;
    logic [7:0]   w_rem_nx;
    logic [15:0]  r_lfsr;
    logic [15:0]  w_lfsr_nx;
    logic [31:0]  r_sym_ct;
    logic         r_valid_o;
    logic         r_window_done;
    logic [W-1:0] r_d_o;
    logic [W-1:0] r_mask;
    logic [15:0]  r_inj_ct;
    logic [15:0]  r_bad_ct;
    logic         w_accept;
    logic         w_trig;
    logic         w_in_win;
    logic         w_inject;
    logic [W-1:0] w_cand_raw;
    logic [W-1:0] w_cand;
    logic [W-1:0] w_mask;
    logic [3:0]   w_pop;
    logic [16:0]  w_bad_sum;

    assign w_accept  = ch.valid_i;
    assign w_trig    = (r_lfsr & TRIG_MSK) == TRIG_MSK;
    assign w_in_win  = r_sym_ct < WIN;
    assign w_lfsr_nx = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);

    // Candidate mask taps the LFSR just above the trigger bits, wrapping around bit 15.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cand
            assign w_cand_raw[gi] = r_lfsr[(N + gi) % 16];
        end
    endgenerate

    assign w_cand = (w_cand_raw == '0) ? W'(1) : w_cand_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_rem   <= w_rem_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_inject   = 1'b0;
        if (w_accept) begin
            if (!w_in_win) begin
                w_state_nx = S_IDLE;
                w_rem_nx   = '0;
            end else begin
                case (ch.mode_i)
                    2'b11: begin
                        w_inject   = 1'b1;
                        w_state_nx = S_IDLE;
                        w_rem_nx   = '0;
                    end
                    2'b10: begin
                        // A trigger seen mid-burst is ignored: the burst neither restarts nor extends.
                        if (r_state == S_BURST) begin
                            w_inject = 1'b1;
                            w_rem_nx = r_rem - 8'd1;
                            if (r_rem == 8'd1) begin
                                w_state_nx = S_IDLE;
                            end
                        end else if (w_trig) begin
                            w_inject = 1'b1;
                            if (MULTI) begin
                                w_state_nx = S_BURST;
                                w_rem_nx   = REM_INIT;
                            end
                        end
                    end
                    2'b01: begin
                        if (r_state == S_BURST) begin
                            w_state_nx = S_IDLE;
                            w_rem_nx   = '0;
                        end else begin
                            w_inject = w_trig;
                        end
                    end
                    default: begin
                        w_state_nx = S_IDLE;
                        w_rem_nx   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_mask = w_inject ? w_cand : '0;
        w_pop  = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + {3'b000, w_mask[i]};
        end
        w_bad_sum = {1'b0, r_bad_ct} + {13'd0, w_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_o     <= 1'b0;
            r_d_o         <= '0;
            r_mask        <= '0;
            r_lfsr        <= SEED;
            r_sym_ct      <= '0;
            r_window_done <= 1'b0;
            r_inj_ct      <= '0;
            r_bad_ct      <= '0;
        end else begin
            r_valid_o <= w_accept;
            if (w_accept) begin
                r_d_o         <= ch.d_i ^ w_mask;
                r_mask        <= w_mask;
                r_lfsr        <= w_lfsr_nx;
                r_window_done <= !w_in_win;
                if (r_sym_ct != 32'hFFFF_FFFF) begin
                    r_sym_ct <= r_sym_ct + 32'd1;
                end
                if (w_inject) begin
                    if (r_inj_ct != 16'hFFFF) begin
                        r_inj_ct <= r_inj_ct + 16'd1;
                    end
                    r_bad_ct <= w_bad_sum[16] ? 16'hFFFF : w_bad_sum[15:0];
                end
            end else begin
                r_mask <= '0;
            end
        end
    end

    assign ch.valid_o    = r_valid_o;
    assign ch.d_o        = r_d_o;
    assign ch.err_mask_o = r_mask;
    assign inj_ct_o      = r_inj_ct;
    assign bad_bit_ct_o  = r_bad_ct;
    assign window_done_o = r_window_done;
endmodule

// File: doc/burst_err_channel.md
BURST_ERR_CHANNEL -- requirements
Module: burst_err_channel

Interface
REQ-001 Parameter W, default 2: symbol width in bits; legal range 1..8.
REQ-002 Parameter N, default 5: rate exponent; trigger when lfsr[N-1:0] is all ones, about 1 in 2**N symbols; legal range 1..8.
REQ-003 Parameter BURST, default 2: symbols corrupted per burst-mode event; legal range 1..255.
REQ-004 Parameter WINDOW, default 256: symbols from reset during which injection is allowed.
REQ-005 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 valid_i  input  1  d_i carries a symbol this cycle.
REQ-009 d_i  input  W  clean encoder symbol.
REQ-010 mode_i  input  2  00 off, 01 random single, 10 random burst, 11 force every symbol.
REQ-011 valid_o  output  1  d_o carries a channel symbol.
REQ-012 d_o  output  W  d_i XOR err_mask_o.
REQ-013 err_mask_o  output  W  mask applied to the current d_o.
REQ-014 inj_ct_o  output  16  number of corrupted symbols; saturates at 16'hFFFF.
REQ-015 bad_bit_ct_o  output  16  number of flipped bits; saturates at 16'hFFFF.
REQ-016 window_done_o  output  1  high once WINDOW symbols have been accepted.

Function
REQ-017 An accepted symbol is a cycle with valid_i=1; d_o, valid_o and err_mask_o are registered, giving 1-cycle latency.
REQ-018 A cycle with valid_i=0 produces: valid_o=0 next cycle, err_mask_o=0, d_o holds, and no LFSR, FSM or counter change.
REQ-019 The LFSR is 16-bit Galois, right-shift, polynomial 16'hB400, and advances once per accepted symbol.
REQ-020 trig and cand_mask are evaluated on the pre-advance LFSR value.
REQ-021 trig = (lfsr[N-1:0] == all ones).
REQ-022 cand_mask = lfsr[N+W-1:N] (wrap index mod 16); if it is zero, cand_mask = 1 so that every injection flips at least one bit.
REQ-023 An internal 32-bit symbol counter counts accepted symbols, saturating.
REQ-024 in_win = (symbol counter < WINDOW), using the pre-increment value.
REQ-025 window_done_o = !in_win, registered.
REQ-026 The FSM has two states, IDLE and BURST, plus an 8-bit remaining count rem.
REQ-027 IDLE, mode 01, trig and in_win: inject cand_mask; stay in IDLE.
REQ-028 IDLE, mode 10, trig and in_win: inject cand_mask; if BURST>1, go to BURST with rem=BURST-1.
REQ-029 BURST, accepted symbol with in_win and mode 10: inject cand_mask regardless of trig; decrement rem; go to IDLE when rem reaches 0.
REQ-030 BURST with mode not 10, or with in_win=0, on an accepted symbol: no injection; return to IDLE with rem=0 (abort).
REQ-031 Mode 11 with in_win: every accepted symbol is injected with cand_mask; the FSM is forced to IDLE.
REQ-032 Mode 00, and any symbol with in_win=0, passes through with err_mask_o=0.
REQ-033 mode_i is sampled only on accepted symbols; a change takes effect on the same symbol.
REQ-034 Each injected symbol adds 1 to inj_ct_o and adds popcount(mask) to bad_bit_ct_o; both saturate and never wrap.
REQ-035 A trigger arriving while in BURST does not extend or restart the burst.

Reset
REQ-036 While rst=0, the following hold: valid_o=0, d_o=0, err_mask_o=0, inj_ct_o=0, bad_bit_ct_o=0, window_done_o=0, lfsr=SEED, symbol counter=0, FSM=IDLE, rem=0.
REQ-037 Reset asserted mid-burst clears everything immediately, without waiting for a clock edge.
REQ-038 The first accepted symbol after reset release uses lfsr=SEED.

Verification
REQ-039 Reset: apply rst=0 with clk running -> all outputs 0; release, drive valid_i=1, d_i=2'b10, mode 00 for 10 cycles -> d_o=2'b10, err_mask_o=0, counters 0.
REQ-040 Force: W=2, WINDOW=256, mode 11, 300 accepted symbols -> first 256 corrupted, inj_ct_o=256, bad_bit_ct_o equals the model popcount sum, window_done_o=1 from symbol 257 with masks 0.
REQ-041 Burst: mode 10, BURST=4 -> each trigger yields exactly 4 consecutive corrupted accepted symbols; triggers during a burst change nothing; results match a cycle model from SEED.
REQ-042 Gaps: mode 01 with valid_i toggled randomly -> err_mask_o sequence over accepted symbols is identical to the gapless run; valid_o=0 in gap cycles.
REQ-043 Abort/reset: mode 10, switch to 00 in the second burst symbol -> that symbol is clean and the FSM is in IDLE; separately, assert rst mid-burst -> outputs 0 asynchronously, and the next run repeats from SEED.
REQ-044 Saturation: mode 11, W=8, WINDOW=2**20 -> bad_bit_ct_o holds 16'hFFFF and never wraps.
